// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the byte-stream program loader.
//   state_t        loader frame-parser states
//   MAGIC_DEFAULT  default start-of-frame byte
//   LEN_W, CSUM_W  frame field widths (length field, checksum field)
//   BYTE_W         width of one stream / memory byte
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
    localparam int         LEN_W         = 16;
    localparam int         CSUM_W        = 8;
    localparam int         BYTE_W        = 8;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream in, memory byte-write port out.
//   s_valid/s_data/s_ready  valid/ready byte stream from the UART/debug bridge
//   mem_we/mem_addr/mem_wdata  byte write port into instruction memory
// Modports:
//   slave   loader side (consumes the stream, drives the write port)
//   master  environment side (drives the stream, observes the write port)
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 7
);
    logic              s_valid;
    logic [BYTE_W-1:0] s_data;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BYTE_W-1:0] mem_wdata;

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a framed program image (MAGIC, LEN_LO, LEN_HI,
// LEN payload bytes, CSUM) on a byte stream and writes payload byte k to
// instruction memory address k. The CPU is held in reset until a complete,
// checksum-verified image is in memory.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus (slave)     byte stream in, memory byte-write port out
//   cpu_hold        keeps the CPU/PC in reset while high
//   done            a valid image is loaded
//   err             frame error (bad length or bad checksum)
//   byte_count      payload bytes written in the current or last frame
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         MEM_BYTES = 100,
    parameter int         ADDR_W    = 7,
    parameter logic [7:0] MAGIC     = MAGIC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    imem_loader_if.slave     bus,
    output logic             cpu_hold,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] byte_count
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MEM_BYTES);

    state_t              state, state_d;
    logic                ready_q;
    logic                xfer;
    logic [LEN_W-1:0]    len;
    logic [LEN_W-1:0]    len_hdr;
    logic [CSUM_W-1:0]   acc;
    logic                start_frame, data_beat, set_done, set_err;

    logic                we_p1;
    logic [ADDR_W-1:0]   addr_p1;
    logic [BYTE_W-1:0]   wdata_p1;

    assign xfer          = bus.s_valid && ready_q;
    // Full length as it will be once the high byte in flight is latched.
    assign len_hdr       = {bus.s_data, len[7:0]};
    assign bus.s_ready   = ready_q;
    assign bus.mem_we    = we_p1;
    assign bus.mem_addr  = addr_p1;
    assign bus.mem_wdata = wdata_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        start_frame = 1'b0;
        data_beat   = 1'b0;
        set_done    = 1'b0;
        set_err     = 1'b0;
        if (xfer) begin
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (bus.s_data == MAGIC) begin
                        state_d = LEN_LO;
                    end
                end
                LEN_LO: state_d = LEN_HI;
                LEN_HI: begin
                    if (len_hdr > MAX_LEN) begin
                        state_d = ERR;
                        set_err = 1'b1;
                    end else begin
                        start_frame = 1'b1;
                        state_d     = (len_hdr == '0) ? CSUM : DATA;
                    end
                end
                DATA: begin
                    data_beat = 1'b1;
                    if (byte_count + 16'd1 == len) begin
                        state_d = CSUM;
                    end
                end
                CSUM: begin
                    if (bus.s_data == acc) begin
                        state_d  = DONE;
                        set_done = 1'b1;
                    end else begin
                        state_d  = ERR;
                        set_err  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Stage p0 -> p1: accepted payload byte becomes a write one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q    <= 1'b0;
            we_p1      <= 1'b0;
            addr_p1    <= '0;
            wdata_p1   <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            byte_count <= '0;
            acc        <= '0;
            len        <= '0;
        end else begin
            ready_q <= 1'b1;
            we_p1   <= data_beat;
            if (xfer && state == LEN_LO) begin
                len[7:0] <= bus.s_data;
            end
            if (xfer && state == LEN_HI) begin
                len[15:8] <= bus.s_data;
            end
            if (start_frame) begin
                byte_count <= '0;
                acc        <= '0;
                cpu_hold   <= 1'b1;
                done       <= 1'b0;
                err        <= 1'b0;
            end
            if (data_beat) begin
                addr_p1    <= byte_count[ADDR_W-1:0];
                wdata_p1   <= bus.s_data;
                byte_count <= byte_count + 16'd1;
                acc        <= acc + bus.s_data;
            end
            if (set_done) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
                err      <= 1'b0;
            end
            if (set_err) begin
                err      <= 1'b1;
                cpu_hold <= 1'b1;
                done     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed-frame bench for imem_loader. A frame-level model
// (header position, payload queue, checksum summed over the queue) predicts
// every output each cycle; hand-computed literals pin the model's results.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int MEM_BYTES = 100;
    localparam int ADDR_W    = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_hold, done, err;
    logic [15:0] byte_count;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(
        .MEM_BYTES(MEM_BYTES),
        .ADDR_W   (ADDR_W),
        .MAGIC    (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Frame-level model: phase 0 hunting MAGIC, 1/2 header bytes, 3 payload,
    // 4 checksum byte; done/err flags say which idle flavour we are in.
    int          m_pos;
    logic [15:0] m_len;
    logic [7:0]  payload[$];
    logic        m_live = 1'b0;
    logic        e_ready = 1'b0, e_we = 1'b0, e_done = 1'b0, e_err = 1'b0, e_hold = 1'b1;
    int          e_addr = 0;
    logic [7:0]  e_wdata = 8'h00;
    int          e_cnt = 0;

    always @(posedge clk) begin
        logic       take;
        logic [7:0] sum;
        take = bus.s_valid && e_ready;
        e_we = 1'b0;
        if (rst) begin
            m_pos = 0; m_len = 16'h0; payload.delete();
            e_ready = 1'b0; e_done = 1'b0; e_err = 1'b0; e_hold = 1'b1; e_cnt = 0;
        end else begin
            e_ready = 1'b1;
            if (take) begin
                if (m_pos == 0) begin
                    if (bus.s_data == 8'hA5) m_pos = 1;
                end else if (m_pos == 1) begin
                    m_len[7:0] = bus.s_data; m_pos = 2;
                end else if (m_pos == 2) begin
                    m_len[15:8] = bus.s_data;
                    if (int'(m_len) > MEM_BYTES) begin
                        m_pos = 0; e_err = 1'b1; e_done = 1'b0; e_hold = 1'b1;
                    end else begin
                        payload.delete(); e_cnt = 0;
                        e_hold = 1'b1; e_done = 1'b0; e_err = 1'b0;
                        m_pos = (m_len == 0) ? 4 : 3;
                    end
                end else if (m_pos == 3) begin
                    e_we = 1'b1; e_addr = payload.size(); e_wdata = bus.s_data;
                    payload.push_back(bus.s_data);
                    e_cnt = payload.size();
                    if (payload.size() == int'(m_len)) m_pos = 4;
                end else begin
                    sum = 8'h00;
                    foreach (payload[i]) sum = sum + payload[i];
                    if (sum == bus.s_data) begin
                        e_done = 1'b1; e_hold = 1'b0; e_err = 1'b0;
                    end else begin
                        e_err = 1'b1; e_hold = 1'b1; e_done = 1'b0;
                    end
                    m_pos = 0;
                end
            end
        end
        m_live = 1'b1;
    end

    // Memory image built from the DUT's write port, for literal word checks.
    logic [7:0] img [0:127];
    int         we_cnt = 0;

    always @(negedge clk) begin
        if (m_live) begin
            chk("s_ready", {31'b0, bus.s_ready}, {31'b0, e_ready});
            chk("mem_we", {31'b0, bus.mem_we}, {31'b0, e_we});
            if (e_we) begin
                chk("mem_addr", {25'b0, bus.mem_addr}, 32'(e_addr));
                chk("mem_wdata", {24'b0, bus.mem_wdata}, {24'b0, e_wdata});
            end
            chk("done", {31'b0, done}, {31'b0, e_done});
            chk("err", {31'b0, err}, {31'b0, e_err});
            chk("cpu_hold", {31'b0, cpu_hold}, {31'b0, e_hold});
            chk("byte_count", {16'b0, byte_count}, 32'(e_cnt));
            if (bus.mem_we === 1'b1) begin
                img[bus.mem_addr] = bus.mem_wdata;
                we_cnt++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        while (bus.s_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout: s_ready=%b, required 1", bus.s_ready);
        end
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f[$], input int gap);
        foreach (f[i]) begin
            send(f[i]);
            if (gap > 0 && i >= 3 && i < f.size() - 1) idle(gap);
        end
    endtask

    task automatic clear_img();
        foreach (img[i]) img[i] = 8'h00;
        we_cnt = 0;
    endtask

    task automatic chk_words(input string tag);
        chk({tag, "_word0"}, {img[3], img[2], img[1], img[0]}, 32'h010F4313);
        chk({tag, "_word4"}, {img[7], img[6], img[5], img[4]}, 32'h00030E13);
    endtask

    logic [7:0] fr[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        rst = 1'b1;
        idle(3);
        chk("rst_s_ready", {31'b0, bus.s_ready}, 32'd0);
        chk("rst_cpu_hold", {31'b0, cpu_hold}, 32'd1);
        chk("rst_mem_addr", {25'b0, bus.mem_addr}, 32'd0);
        chk("rst_mem_wdata", {24'b0, bus.mem_wdata}, 32'd0);
        rst = 1'b0;
        idle(2);
        chk("ready_after_rst", {31'b0, bus.s_ready}, 32'd1);

        // Good 8-byte frame
        clear_img();
        fr = '{8'hA5, 8'h08, 8'h00, 8'h13, 8'h43, 8'h0F, 8'h01, 8'h13, 8'h0E, 8'h03, 8'h00, 8'h8A};
        send_frame(fr, 0);
        idle(2);
        chk_words("good");
        chk("good_done", {31'b0, done}, 32'd1);
        chk("good_hold", {31'b0, cpu_hold}, 32'd0);
        chk("good_err", {31'b0, err}, 32'd0);
        chk("good_count", {16'b0, byte_count}, 32'd8);
        chk("good_writes", 32'(we_cnt), 32'd8);

        // Same frame, wrong checksum
        clear_img();
        fr[11] = 8'h8B;
        send_frame(fr, 0);
        idle(2);
        chk("badcs_err", {31'b0, err}, 32'd1);
        chk("badcs_done", {31'b0, done}, 32'd0);
        chk("badcs_hold", {31'b0, cpu_hold}, 32'd1);
        chk("badcs_writes", 32'(we_cnt), 32'd8);

        // Oversize length, trailing bytes ignored
        clear_img();
        fr = '{8'hA5, 8'h65, 8'h00, 8'h11, 8'h22, 8'h33};
        send_frame(fr, 0);
        idle(2);
        chk("oversize_err", {31'b0, err}, 32'd1);
        chk("oversize_hold", {31'b0, cpu_hold}, 32'd1);
        chk("oversize_writes", 32'(we_cnt), 32'd0);

        // Noise before MAGIC, gaps between payload bytes
        clear_img();
        send(8'h00);
        send(8'hFF);
        fr = '{8'hA5, 8'h08, 8'h00, 8'h13, 8'h43, 8'h0F, 8'h01, 8'h13, 8'h0E, 8'h03, 8'h00, 8'h8A};
        send_frame(fr, 3);
        idle(2);
        chk_words("gap");
        chk("gap_done", {31'b0, done}, 32'd1);
        chk("gap_writes", 32'(we_cnt), 32'd8);

        // rst after the 3rd payload byte, then a full reload
        clear_img();
        fr = '{8'hA5, 8'h08, 8'h00, 8'h13, 8'h43, 8'h0F};
        send_frame(fr, 0);
        rst = 1'b1;
        idle(1);
        chk("midrst_s_ready", {31'b0, bus.s_ready}, 32'd0);
        chk("midrst_hold", {31'b0, cpu_hold}, 32'd1);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_we", {31'b0, bus.mem_we}, 32'd0);
        chk("midrst_count", {16'b0, byte_count}, 32'd0);
        rst = 1'b0;
        idle(1);
        clear_img();
        fr = '{8'hA5, 8'h08, 8'h00, 8'h13, 8'h43, 8'h0F, 8'h01, 8'h13, 8'h0E, 8'h03, 8'h00, 8'h8A};
        send_frame(fr, 0);
        idle(2);
        chk_words("afterrst");
        chk("afterrst_done", {31'b0, done}, 32'd1);

        // Zero-length frame, then reload
        clear_img();
        fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(fr, 0);
        idle(2);
        chk("zero_done", {31'b0, done}, 32'd1);
        chk("zero_hold", {31'b0, cpu_hold}, 32'd0);
        chk("zero_count", {16'b0, byte_count}, 32'd0);
        chk("zero_writes", 32'(we_cnt), 32'd0);
        fr = '{8'hA5, 8'h08, 8'h00};
        send_frame(fr, 0);
        chk("reload_hold", {31'b0, cpu_hold}, 32'd1);
        chk("reload_done", {31'b0, done}, 32'd0);
        fr = '{8'h13, 8'h43, 8'h0F, 8'h01, 8'h13, 8'h0E, 8'h03, 8'h00, 8'h8A};
        send_frame(fr, 0);
        idle(2);
        chk_words("reload");
        chk("reload_done_end", {31'b0, done}, 32'd1);
        chk("reload_hold_end", {31'b0, cpu_hold}, 32'd0);
        chk("reload_count", {16'b0, byte_count}, 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader; the write-side counterpart of the byte-addressed instruction memory.
- Receives a framed program image on a valid/ready byte stream (from a UART/debug bridge) and writes it byte-by-byte into instruction memory through a write port.
- Holds the CPU (cpu_hold) until a complete, checksum-verified image is in memory.
- Byte k of the payload goes to address k, so the CPU reads little-endian words starting at PC=0.

Parameters:
- MEM_BYTES, 100, instruction memory size in bytes; the largest legal payload length.
- ADDR_W, 7, memory address width; must satisfy 2^ADDR_W >= MEM_BYTES.
- MAGIC, 8'hA5, start-of-frame byte.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset.
- s_valid  in  1  input byte valid.
- s_data  in  8  input byte.
- s_ready  out  1  loader accepts a byte; a transfer occurs when s_valid && s_ready at a clk edge.
- mem_we  out  1  memory byte write strobe, one cycle per payload byte.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  8  write data.
- cpu_hold  out  1  keeps the CPU/PC in reset while high.
- done  out  1  a valid image is loaded.
- err  out  1  frame error (bad length or bad checksum).
- byte_count  out  16  payload bytes written in the current or last frame.

Behaviour:
- Reset is rst, synchronous, active-high.
  - Reset values: s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, err=0, byte_count=0, state=IDLE.
- s_ready is registered.
  - It is 1 in every state from the first cycle after rst deasserts.
  - It is 0 only while rst is high.
- Frame format: MAGIC, LEN_LO, LEN_HI, LEN payload bytes, CSUM.
  - CSUM = 8-bit sum, mod 256, of the payload bytes.
- States and transitions (all advance only on a transfer; s_valid gaps hold state):
  - IDLE: MAGIC -> LEN_LO. Any other byte is discarded.
  - LEN_LO: latch len[7:0] -> LEN_HI.
  - LEN_HI: latch len[15:8].
    - len > MEM_BYTES -> ERR.
    - len == 0 -> CSUM.
    - otherwise -> DATA.
    - Entering DATA or CSUM clears byte_count and the accumulator, and sets cpu_hold=1, done=0, err=0.
  - DATA: each transfer does the following.
    - Next cycle (1-cycle latency): mem_we=1, mem_addr=byte_count, mem_wdata=s_data.
    - byte_count increments and the accumulator += s_data.
    - After the len-th byte -> CSUM.
  - CSUM: byte == accumulator -> DONE; otherwise -> ERR.
  - DONE: done=1, cpu_hold=0, err=0. MAGIC -> LEN_LO (reload); other bytes are ignored.
  - ERR: err=1, cpu_hold=1, done=0. MAGIC -> LEN_LO (retry); other bytes are ignored.
- On reload or retry, done, err and cpu_hold keep their values through LEN_LO/LEN_HI. They change on leaving LEN_HI, as specified above.
- mem_we is 0 in every cycle not immediately following a DATA transfer. Writes are never issued for header or CSUM bytes.
- Bytes written before an error are not rolled back. cpu_hold stays high, so the CPU never runs a partial image.
- Address arithmetic:
  - mem_addr = byte_count[ADDR_W-1:0].
  - byte_count never exceeds len <= MEM_BYTES, so no wrap occurs.
- rst mid-frame (any state) restores all reset values on the next edge. A write scheduled for the following cycle is cancelled.
- A MAGIC value appearing inside LEN_LO, LEN_HI, DATA or CSUM is treated as ordinary data (no resync).

Decomposition:
- Shared package imem_loader_pkg:
  - state enum (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR);
  - MAGIC default;
  - frame field widths (LEN 16, CSUM 8).
- Single module; no sub-module. The checksum accumulator and write register are a few lines each.
- Top level instantiates imem_loader beside the instruction memory and gates the PC reset with cpu_hold.

Test Plan:
- Good 8-byte frame:
  - Stimulus: rst, then A5 08 00 13 43 0F 01 13 0E 03 00 8A.
  - Response: writes addr 0..7 = 13,43,0F,01,13,0E,03,00; the CPU then reads word@0 = 01_0F_43_13 and word@4 = 00_03_0E_13; done=1, cpu_hold=0, byte_count=8, err=0.
- Same frame with CSUM 8B -> err=1, done=0, cpu_hold=1; 8 writes still occur.
- Oversize length A5 65 00 (101 > 100) -> ERR after the LEN_HI transfer, zero mem_we pulses; following payload bytes are ignored.
- Noise and gaps: 00 FF before MAGIC, plus s_valid low for 3 cycles between payload bytes -> noise discarded, state held during gaps, load completes normally.
- rst pulsed after the 3rd payload byte -> all outputs return to reset values (cpu_hold=1, s_ready=0 during rst); the next full frame loads correctly.
- Zero-length frame and reload:
  - A5 00 00 00 -> DONE with no writes, byte_count=0.
  - A second good frame then reasserts cpu_hold=1 on leaving LEN_HI and ends with done=1, cpu_hold=0.
